// File: rtl/bc_stage_id_pipe.sv
// bc_stage_id_pipe: RV32I decode stage with operand forwarding, load-use stall, flush and one registered output slot.
module bc_stage_id_pipe #(
    parameter int DATA_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_FWD     = 2
) (
    input  logic                          i_clk,
    input  logic                          i_rstn,
    input  logic                          i_instr_valid,
    output logic                          o_instr_ready,
    input  logic [INSTR_WIDTH-1:0]        i_instr,
    input  logic [DATA_WIDTH-1:0]         i_pc,
    input  logic                          i_flush,
    output logic [4:0]                    o_rs1_addr,
    output logic [4:0]                    o_rs2_addr,
    input  logic [DATA_WIDTH-1:0]         i_rs1_data,
    input  logic [DATA_WIDTH-1:0]         i_rs2_data,
    input  logic [NUM_FWD-1:0]            i_fwd_valid,
    input  logic [5*NUM_FWD-1:0]          i_fwd_addr,
    input  logic [DATA_WIDTH*NUM_FWD-1:0] i_fwd_data,
    input  logic                          i_ex_load_valid,
    input  logic [4:0]                    i_ex_load_rd,
    output logic                          o_decode_valid,
    input  logic                          i_decode_ready,
    output logic [DATA_WIDTH-1:0]         o_pc,
    output logic [DATA_WIDTH-1:0]         o_rs1_data,
    output logic [DATA_WIDTH-1:0]         o_rs2_data,
    output logic [DATA_WIDTH-1:0]         o_imm,
    output logic                          o_rd_wen,
    output logic [4:0]                    o_rd_addr,
    output logic [6:0]                    o_opcode,
    output logic [2:0]                    o_funct3,
    output logic                          o_illegal
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_MISC   = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [31:0] ins;
    logic [6:0] opc;
    logic is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store, is_opimm, is_op, is_known;
    logic use_rs1, use_rs2, hazard, adv, load;
    logic rd_wen, illegal;
    logic [DATA_WIDTH-1:0] rs1_val, rs2_val, imm;

    assign ins       = i_instr[31:0];
    assign opc       = ins[6:0];
    assign is_lui    = opc == OP_LUI;
    assign is_auipc  = opc == OP_AUIPC;
    assign is_jal    = opc == OP_JAL;
    assign is_jalr   = opc == OP_JALR;
    assign is_branch = opc == OP_BRANCH;
    assign is_load   = opc == OP_LOAD;
    assign is_store  = opc == OP_STORE;
    assign is_opimm  = opc == OP_IMM;
    assign is_op     = opc == OP_OP;
    assign is_known  = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                       is_opimm | is_op | opc == OP_MISC | opc == OP_SYSTEM;

    assign o_rs1_addr = ins[19:15];
    assign o_rs2_addr = ins[24:20];

    assign use_rs1 = !(is_lui | is_auipc | is_jal);
    assign use_rs2 = is_op | is_store | is_branch;
    assign hazard  = i_instr_valid & i_ex_load_valid & (i_ex_load_rd != 5'd0) &
                     ((use_rs1 & (o_rs1_addr == i_ex_load_rd)) | (use_rs2 & (o_rs2_addr == i_ex_load_rd)));
    assign adv           = !o_decode_valid | i_decode_ready;
    assign o_instr_ready = i_flush | (adv & !hazard);
    assign load          = !i_flush & adv & i_instr_valid & !hazard;

    // Walk from the oldest source down so the lowest index overrides.
    always_comb begin
        rs1_val = i_rs1_data;
        rs2_val = i_rs2_data;
        for (int k = NUM_FWD - 1; k >= 0; k--) begin
            if (i_fwd_valid[k] && i_fwd_addr[k*5 +: 5] == o_rs1_addr) rs1_val = i_fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
            if (i_fwd_valid[k] && i_fwd_addr[k*5 +: 5] == o_rs2_addr) rs2_val = i_fwd_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
        if (o_rs1_addr == 5'd0) rs1_val = '0;
        if (o_rs2_addr == 5'd0) rs2_val = '0;
    end

    always_comb begin
        imm = (is_opimm | is_load | is_jalr) ? {{(DATA_WIDTH-11){ins[31]}}, ins[30:20]} :
              is_store                     ? {{(DATA_WIDTH-11){ins[31]}}, ins[30:25], ins[11:7]} :
              is_branch                    ? {{(DATA_WIDTH-12){ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0} :
              (is_lui | is_auipc)          ? {{(DATA_WIDTH-31){ins[31]}}, ins[30:12], 12'b0} :
              is_jal                       ? {{(DATA_WIDTH-20){ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0} :
                                             '0;
    end

    assign illegal = !is_known | (ins[1:0] != 2'b11);
    assign rd_wen  = (is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op) & (ins[11:7] != 5'd0);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) o_decode_valid <= 1'b0;
        else if (i_flush) o_decode_valid <= 1'b0;
        else if (adv) o_decode_valid <= i_instr_valid & !hazard;
    end

    // Payload is deliberately unreset; it is only meaningful while o_decode_valid is high.
    always_ff @(posedge i_clk) begin
        if (load) begin
            o_pc       <= i_pc;
            o_rs1_data <= rs1_val;
            o_rs2_data <= rs2_val;
            o_imm      <= imm;
            o_rd_wen   <= rd_wen;
            o_rd_addr  <= ins[11:7];
            o_opcode   <= opc;
            o_funct3   <= ins[14:12];
            o_illegal  <= illegal;
        end
    end
endmodule

// File: tb/tb_bc_stage_id_pipe.sv
// tb_bc_stage_id_pipe: directed and randomized checks of the decode stage against a behavioural model.
module tb_bc_stage_id_pipe;
    logic        i_clk = 1'b0;
    logic        i_rstn = 1'b0;
    logic        i_instr_valid, i_flush, i_ex_load_valid, i_decode_ready;
    logic [31:0] i_instr, i_pc, i_rs1_data, i_rs2_data;
    logic [1:0]  i_fwd_valid;
    logic [4:0]  fa [2];
    logic [31:0] fd [2];
    logic [9:0]  i_fwd_addr;
    logic [63:0] i_fwd_data;
    logic [4:0]  i_ex_load_rd;
    logic        o_instr_ready, o_decode_valid, o_rd_wen, o_illegal;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr;
    logic [31:0] o_pc, o_rs1_data, o_rs2_data, o_imm;
    logic [6:0]  o_opcode;
    logic [2:0]  o_funct3;

    assign i_fwd_addr = {fa[1], fa[0]};
    assign i_fwd_data = {fd[1], fd[0]};

    always #5 i_clk = ~i_clk;

    bc_stage_id_pipe dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_instr_valid(i_instr_valid), .o_instr_ready(o_instr_ready),
        .i_instr(i_instr), .i_pc(i_pc), .i_flush(i_flush), .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data), .i_fwd_valid(i_fwd_valid), .i_fwd_addr(i_fwd_addr),
        .i_fwd_data(i_fwd_data), .i_ex_load_valid(i_ex_load_valid), .i_ex_load_rd(i_ex_load_rd),
        .o_decode_valid(o_decode_valid), .i_decode_ready(i_decode_ready), .o_pc(o_pc), .o_rs1_data(o_rs1_data),
        .o_rs2_data(o_rs2_data), .o_imm(o_imm), .o_rd_wen(o_rd_wen), .o_rd_addr(o_rd_addr), .o_opcode(o_opcode),
        .o_funct3(o_funct3), .o_illegal(o_illegal)
    );

    localparam logic [6:0] LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F, JALR = 7'h67, BRANCH = 7'h63, LOAD = 7'h03,
                           STORE = 7'h23, OPIMM = 7'h13, OP = 7'h33, MISC = 7'h0F, SYSTEM = 7'h73;
    logic [6:0] ops [11] = '{LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM};

    int checks = 0;
    int errors = 0;
    logic         m_valid = 1'b0;
    logic [144:0] m_pay;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] opnd(input logic [4:0] a, input logic [31:0] rf);
        logic [31:0] r = rf;
        logic found = 1'b0;
        if (a == 5'd0) return 32'd0;
        for (int k = 0; k < 2; k++)
            if (!found && i_fwd_valid[k] && fa[k] == a) begin
                r = fd[k];
                found = 1'b1;
            end
        return r;
    endfunction

    function automatic logic [31:0] ref_imm(input logic [31:0] u);
        logic signed [31:0] s = u;
        logic [31:0] hi = s >>> 31;
        logic [6:0] op = u[6:0];
        if (op inside {OPIMM, LOAD, JALR}) return (hi << 11) | ((u >> 20) & 32'h7FF);
        if (op == STORE) return (hi << 11) | (((u >> 25) & 32'h3F) << 5) | ((u >> 7) & 32'h1F);
        if (op == BRANCH) return (hi << 12) | (((u >> 7) & 32'h1) << 11) | (((u >> 25) & 32'h3F) << 5) | (((u >> 8) & 32'hF) << 1);
        if (op inside {LUI, AUIPC}) return u & 32'hFFFFF000;
        if (op == JAL) return (hi << 20) | (((u >> 12) & 32'hFF) << 12) | (((u >> 20) & 32'h1) << 11) | (((u >> 21) & 32'h3FF) << 1);
        return 32'd0;
    endfunction

    function automatic logic ref_hazard();
        logic [6:0] op = i_instr[6:0];
        logic u1 = !(op inside {LUI, AUIPC, JAL});
        logic u2 = op inside {OP, STORE, BRANCH};
        return i_instr_valid && i_ex_load_valid && i_ex_load_rd != 5'd0 &&
               ((u1 && i_instr[19:15] == i_ex_load_rd) || (u2 && i_instr[24:20] == i_ex_load_rd));
    endfunction

    task automatic cycle();
        logic hz, adv, wen, ill;
        #1;
        hz  = ref_hazard();
        adv = !m_valid || i_decode_ready;
        chk("instr_ready", 160'(o_instr_ready), 160'(i_flush || (adv && !hz)));
        chk("rs_addr", 160'({o_rs1_addr, o_rs2_addr}), 160'({i_instr[19:15], i_instr[24:20]}));
        wen = i_instr[6:0] inside {LUI, AUIPC, JAL, JALR, LOAD, OPIMM, OP} && i_instr[11:7] != 5'd0;
        ill = !(i_instr[6:0] inside {LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP, MISC, SYSTEM}) || i_instr[1:0] != 2'b11;
        if (i_flush) m_valid = 1'b0;
        else if (adv && i_instr_valid && !hz) begin
            m_valid = 1'b1;
            m_pay = {i_pc, opnd(i_instr[19:15], i_rs1_data), opnd(i_instr[24:20], i_rs2_data), ref_imm(i_instr),
                     wen, i_instr[11:7], i_instr[6:0], i_instr[14:12], ill};
        end else if (adv) m_valid = 1'b0;
        @(posedge i_clk);
        #1;
        chk("decode_valid", 160'(o_decode_valid), 160'(m_valid));
        if (m_valid)
            chk("payload", 160'({o_pc, o_rs1_data, o_rs2_data, o_imm, o_rd_wen, o_rd_addr, o_opcode, o_funct3, o_illegal}),
                160'(m_pay));
    endtask

    initial begin
        logic [31:0] w;
        int idx;
        i_instr_valid = 0; i_flush = 0; i_ex_load_valid = 0; i_ex_load_rd = 0; i_decode_ready = 1;
        i_instr = 0; i_pc = 0; i_rs1_data = 0; i_rs2_data = 0; i_fwd_valid = 0;
        fa[0] = 0; fa[1] = 0; fd[0] = 0; fd[1] = 0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_valid", 160'(o_decode_valid), 160'(0));
        i_rstn = 1;

        i_instr = 32'hFFF08293; i_pc = 32'h100; i_instr_valid = 1; i_rs1_data = 10; i_rs2_data = 7;
        cycle();
        chk("addi_rs1", 160'(o_rs1_data), 160'(10));
        chk("addi_imm", 160'(o_imm), 160'(32'hFFFFFFFF));
        chk("addi_wen", 160'({o_rd_wen, o_rd_addr}), 160'({1'b1, 5'd5}));

        i_instr = 32'h002081B3; i_pc = 32'h104; i_rs1_data = 32'h99; i_fwd_valid = 2'b11;
        fa[0] = 1; fa[1] = 1; fd[0] = 32'h11; fd[1] = 32'h22;
        cycle();
        chk("fwd_prio", 160'(o_rs1_data), 160'(32'h11));

        i_instr = 32'h002001B3; i_pc = 32'h108; fa[0] = 0; fd[0] = 32'h55;
        cycle();
        chk("fwd_x0", 160'(o_rs1_data), 160'(0));

        i_instr = 32'h0020A223; i_pc = 32'h10C; i_fwd_valid = 0; i_ex_load_valid = 1; i_ex_load_rd = 2;
        repeat (2) begin
            cycle();
            chk("stall_bubble", 160'(o_decode_valid), 160'(0));
        end
        i_ex_load_valid = 0;
        cycle();
        chk("sw_imm", 160'(o_imm), 160'(4));

        i_instr = 32'h00108313; i_pc = 32'h200; i_decode_ready = 0;
        repeat (3) begin
            cycle();
            chk("bp_hold_pc", 160'(o_pc), 160'(32'h10C));
        end
        i_decode_ready = 1;
        cycle();
        chk("bp_next_pc", 160'(o_pc), 160'(32'h200));

        i_decode_ready = 0; i_flush = 1; i_instr = 32'h00208313; i_pc = 32'h204;
        cycle();
        chk("flush_valid", 160'(o_decode_valid), 160'(0));
        i_flush = 0; i_decode_ready = 1; i_instr = 32'h0000007F; i_pc = 32'h208;
        cycle();
        chk("illegal", 160'({o_illegal, o_rd_wen}), 160'(2'b10));

        for (int n = 0; n < 400; n++) begin
            idx = $urandom_range(0, 11);
            w = $urandom;
            w[6:0] = idx == 11 ? 7'($urandom) : ops[idx];
            w[19:15] = 5'($urandom_range(0, 3));
            w[24:20] = 5'($urandom_range(0, 3));
            i_instr = w; i_pc = $urandom; i_rs1_data = $urandom; i_rs2_data = $urandom;
            i_instr_valid = $urandom_range(0, 3) != 0;
            i_decode_ready = $urandom_range(0, 3) != 0;
            i_flush = $urandom_range(0, 9) == 0;
            i_ex_load_valid = $urandom_range(0, 2) == 0;
            i_ex_load_rd = 5'($urandom_range(0, 3));
            i_fwd_valid = 2'($urandom);
            fa[0] = 5'($urandom_range(0, 3)); fa[1] = 5'($urandom_range(0, 3));
            fd[0] = $urandom; fd[1] = $urandom;
            cycle();
        end

        i_flush = 0; i_ex_load_valid = 0; i_instr_valid = 1; i_decode_ready = 0; i_instr = 32'h00108313;
        cycle();
        i_rstn = 0;
        #1;
        chk("async_reset", 160'(o_decode_valid), 160'(0));
        m_valid = 1'b0;
        @(posedge i_clk);
        #1;
        i_rstn = 1;
        i_decode_ready = 1;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
